// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB master sequencer.
// Contents: peripheral register offsets, the default CMD start value, the
// sequencer state encoding and a helper that maps a macro step to its offset.
package apb_master_pkg;

    localparam logic [5:0] OFF_CONFIG = 6'h00;
    localparam logic [5:0] OFF_TX     = 6'h04;
    localparam logic [5:0] OFF_CMD    = 6'h0C;

    localparam logic [7:0] CMD_START_DEFAULT = 8'h02;

    // Macro steps are numbered 0 (CONFIG), 1 (TX), 2 (CMD).
    localparam logic [1:0] STEP_LAST = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StAccess,
        StGap,
        StResp
    } state_e;

    function automatic logic [5:0] macro_offset(input logic [1:0] step);
        logic [5:0] off;
        case (step)
            2'd0:    off = OFF_CONFIG;
            2'd1:    off = OFF_TX;
            default: off = OFF_CMD;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait timer.
// Counts cycles in which the slave holds PREADY low and flags the cycle that
// would be the TIMEOUT_CYCLES-th such cycle, so the master can abort on that edge.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   clear_i    restart the count (asserted during SETUP)
//   en_i       count this cycle (ACCESS with PREADY low)
//   expired_o  this wait cycle exhausts the budget; constant 0 when TIMEOUT_CYCLES is 0
module apb_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    if (TIMEOUT_CYCLES == 0) begin : g_disabled
        assign expired_o = 1'b0;
    end else begin : g_enabled
        localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

        logic [CntW-1:0] count_q;

        always_ff @(posedge clk_i) begin
            if (rst_i || clear_i) begin
                count_q <= '0;
            end else if (en_i) begin
                count_q <= count_q + CntW'(1);
            end
        end

        // Fires on the wait cycle whose count would reach TIMEOUT_CYCLES.
        assign expired_o = en_i && (count_q == CntW'(TIMEOUT_CYCLES - 1));
    end

endmodule

// File: rtl/apb_master_seq.sv
// APB initiator for the SPI/RF peripheral.
// Runs single register reads/writes from the REQ port, or a three-write
// byte-transfer macro (CONFIG, TX, CMD=start) from the XFER port. The macro
// wins when both are offered. All bus and response outputs are registered.
// Ports:
//   i_PCLK, i_PRESET                 clock, synchronous active-high reset
//   i_BASE_ADDR                      peripheral base, becomes PADDR[15:6]
//   i_REQ_*                          single transaction request
//   i_XFER_*                         byte-transfer macro request
//   o_REQ_READY                      either request accepted this cycle
//   o_RSP_VALID/RDATA/ERR            one-cycle completion with read data / timeout flag
//   o_BUSY                           sequencer not idle
//   o_PSEL0 .. o_PWDATA, i_PREADY,
//   i_PRDATA                         APB master signals
module apb_master_seq
    import apb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [7:0]  CMD_START      = CMD_START_DEFAULT
) (
    input  logic        i_PCLK,
    input  logic        i_PRESET,
    input  logic [9:0]  i_BASE_ADDR,
    input  logic        i_REQ_VALID,
    input  logic        i_REQ_WRITE,
    input  logic [5:0]  i_REQ_OFFSET,
    input  logic [7:0]  i_REQ_WDATA,
    input  logic        i_XFER_VALID,
    input  logic [7:0]  i_XFER_CFG,
    input  logic [7:0]  i_XFER_DATA,
    output logic        o_REQ_READY,
    output logic        o_RSP_VALID,
    output logic [7:0]  o_RSP_RDATA,
    output logic        o_RSP_ERR,
    output logic        o_BUSY,
    output logic        o_PSEL0,
    output logic        o_PENABLE,
    output logic        o_PWRITE,
    output logic [15:0] o_PADDR,
    output logic [7:0]  o_PWDATA,
    input  logic        i_PREADY,
    input  logic [7:0]  i_PRDATA
);

    state_e      state_q;
    logic [1:0]  step_q;
    logic        macro_q;
    logic [9:0]  base_q;
    logic [7:0]  data_q;

    logic        psel_q;
    logic        penable_q;
    logic        pwrite_q;
    logic [15:0] paddr_q;
    logic [7:0]  pwdata_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_rdata_q;
    logic        rsp_err_q;
    logic        busy_q;

    logic timer_clear;
    logic timer_en;
    logic timer_expired;

    assign timer_clear = (state_q == StSetup);
    assign timer_en    = (state_q == StAccess) && !i_PREADY;

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk_i    (i_PCLK),
        .rst_i    (i_PRESET),
        .clear_i  (timer_clear),
        .en_i     (timer_en),
        .expired_o(timer_expired)
    );

    always_ff @(posedge i_PCLK) begin
        if (i_PRESET) begin
            state_q     <= StIdle;
            step_q      <= '0;
            macro_q     <= 1'b0;
            base_q      <= '0;
            data_q      <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // The first SETUP is launched straight from the request inputs.
                    if (i_XFER_VALID) begin
                        macro_q  <= 1'b1;
                        step_q   <= 2'd0;
                        base_q   <= i_BASE_ADDR;
                        data_q   <= i_XFER_DATA;
                        psel_q   <= 1'b1;
                        pwrite_q <= 1'b1;
                        paddr_q  <= {i_BASE_ADDR, OFF_CONFIG};
                        pwdata_q <= i_XFER_CFG;
                        busy_q   <= 1'b1;
                        state_q  <= StSetup;
                    end else if (i_REQ_VALID) begin
                        macro_q  <= 1'b0;
                        step_q   <= 2'd0;
                        base_q   <= i_BASE_ADDR;
                        psel_q   <= 1'b1;
                        pwrite_q <= i_REQ_WRITE;
                        paddr_q  <= {i_BASE_ADDR, i_REQ_OFFSET};
                        pwdata_q <= i_REQ_WDATA;
                        busy_q   <= 1'b1;
                        state_q  <= StSetup;
                    end
                end
                StSetup: begin
                    penable_q <= 1'b1;
                    state_q   <= StAccess;
                end
                StAccess: begin
                    if (i_PREADY) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        pwrite_q  <= 1'b0;
                        if (macro_q && (step_q != STEP_LAST)) begin
                            step_q  <= step_q + 2'd1;
                            state_q <= StGap;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            // pwrite_q still holds the direction of the finishing transfer.
                            rsp_rdata_q <= (!macro_q && !pwrite_q) ? i_PRDATA : 8'h00;
                            state_q     <= StResp;
                        end
                    end else if (timer_expired) begin
                        // Abort: any remaining macro steps are dropped.
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        pwrite_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= 8'h00;
                        state_q     <= StResp;
                    end
                end
                StGap: begin
                    psel_q   <= 1'b1;
                    pwrite_q <= 1'b1;
                    paddr_q  <= {base_q, macro_offset(step_q)};
                    pwdata_q <= (step_q == 2'd1) ? data_q : CMD_START;
                    state_q  <= StSetup;
                end
                StResp: begin
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 8'h00;
                    busy_q      <= 1'b0;
                    state_q     <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // READY is a decode of the registered state, forced low while reset is held.
    assign o_REQ_READY = (state_q == StIdle) && !i_PRESET;
    assign o_RSP_VALID = rsp_valid_q;
    assign o_RSP_RDATA = rsp_rdata_q;
    assign o_RSP_ERR   = rsp_err_q;
    assign o_BUSY      = busy_q;
    assign o_PSEL0     = psel_q;
    assign o_PENABLE   = penable_q;
    assign o_PWRITE    = pwrite_q;
    assign o_PADDR     = paddr_q;
    assign o_PWDATA    = pwdata_q;

endmodule
